// File: rtl/uart_fifo_bridge.sv
// Byte-buffering bridge between the UART engines and the serial slave.
// RX FIFO captures received bytes; TX FIFO feeds the transmitter through a start/busy FSM.
module uart_fifo_bridge #(
  parameter int unsigned RX_DEPTH      = 16,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                        clk_bus,
  input  logic                        rst_bus_n,
  input  logic                        uart_rx_ready,
  input  logic [7:0]                  uart_rx_data,
  output logic                        uart_rx_clear,
  input  logic                        uart_tx_busy,
  output logic                        uart_tx_start,
  output logic [7:0]                  uart_tx_data,
  input  logic                        rx_pop,
  output logic [7:0]                  rx_data,
  output logic                        rx_empty,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  input  logic                        tx_push,
  input  logic [7:0]                  tx_wdata,
  output logic                        tx_full,
  output logic                        tx_idle,
  output logic                        rx_overrun,
  input  logic                        ovr_clr
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned TMR_W = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT_BUSY, ST_WAIT_DONE} tx_state_e;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic             clr_q, ovr_q;
  logic             rx_cap_c, rx_full_c, rx_push_c, rx_drop_c, rx_pop_c;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_full_q, tx_idle_q, start_q;
  logic [7:0]       tx_data_q;
  logic             tx_push_c, tx_pop_c;

  tx_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // A pending clear blocks re-sampling of the level-held ready flag.
  always_comb begin
    rx_cap_c  = uart_rx_ready && !clr_q;
    rx_full_c = (rx_cnt_q == RX_CW'(RX_DEPTH));
    rx_push_c = rx_cap_c && !rx_full_c;
    rx_drop_c = rx_cap_c && rx_full_c;
    rx_pop_c  = rx_pop && (rx_cnt_q != '0);
    rx_cnt_d  = rx_cnt_q + RX_CW'(rx_push_c) - RX_CW'(rx_pop_c);
  end

  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      clr_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      clr_q    <= rx_cap_c;
      if (rx_push_c) rx_wr_q <= rx_wr_q + RX_AW'(1);
      if (rx_pop_c)  rx_rd_q <= rx_rd_q + RX_AW'(1);
      if (rx_drop_c)    ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (rx_push_c) rx_mem[rx_wr_q] <= uart_rx_data;
  end

  assign rx_data       = (rx_cnt_q == '0) ? 8'h00 : rx_mem[rx_rd_q];
  assign rx_empty      = (rx_cnt_q == '0);
  assign rx_count      = rx_cnt_q;
  assign rx_overrun    = ovr_q;
  assign uart_rx_clear = clr_q;

  // TX FSM next state; the timeout treats an unacknowledged start as sent.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    tx_pop_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((tx_cnt_q != '0) && !uart_tx_busy) begin
          tx_pop_c = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tmr_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_tx_busy)                               state_d = ST_WAIT_DONE;
        else if (tmr_q == TMR_W'(START_TIMEOUT - 1))    state_d = ST_IDLE;
        else                                            tmr_d   = tmr_q + TMR_W'(1);
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_push_c = tx_push && !tx_full_q;
    tx_cnt_d  = tx_cnt_q + TX_CW'(tx_push_c) - TX_CW'(tx_pop_c);
  end

  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      tx_full_q <= 1'b0;
      tx_idle_q <= 1'b1;
      start_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_full_q <= (tx_cnt_d == TX_CW'(TX_DEPTH));
      tx_idle_q <= (tx_cnt_d == '0) && (state_d == ST_IDLE);
      start_q   <= (state_d == ST_START);
      if (tx_push_c) tx_wr_q <= tx_wr_q + TX_AW'(1);
      if (tx_pop_c) begin
        tx_rd_q   <= tx_rd_q + TX_AW'(1);
        tx_data_q <= tx_mem[tx_rd_q];
      end
    end
  end

  always_ff @(posedge clk_bus) begin
    if (tx_push_c) tx_mem[tx_wr_q] <= tx_wdata;
  end

  assign tx_full       = tx_full_q;
  assign tx_idle       = tx_idle_q;
  assign uart_tx_start = start_q;
  assign uart_tx_data  = tx_data_q;

endmodule
